// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller.
package elevator_pkg;
    typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_e;

    localparam int              FLOOR_W    = 4;
    localparam int              NUM_FLOORS = 1 << FLOOR_W;
    localparam logic [FLOOR_W-1:0] MIN_FLOOR = 4'd1;
    localparam logic [FLOOR_W-1:0] MAX_FLOOR = 4'd15;
    localparam logic            DIR_UP     = 1'b1;
    localparam logic            DIR_DOWN   = 1'b0;
endpackage

// File: rtl/elevator_request_queue.sv
// Pending floor-request set with "any request above / below" lookups.
module elevator_request_queue
    import elevator_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FLOOR_W-1:0]    set_floor_i,
    input  logic                  clr_en_i,
    input  logic [FLOOR_W-1:0]    clr_floor_i,
    input  logic [FLOOR_W-1:0]    query_floor_i,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  above_o,
    output logic                  below_o
);
    logic [NUM_FLOORS-1:0] pending_q, pending_d;

    // Clear is applied after set so a request landing on the floor being served is absorbed.
    always_comb begin
        pending_d = pending_q;
        if (set_floor_i != '0) pending_d[set_floor_i] = 1'b1;
        if (clr_en_i)          pending_d[clr_floor_i] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    always_comb begin
        above_o = 1'b0;
        below_o = 1'b0;
        for (int i = 1; i < NUM_FLOORS; i++) begin
            if (pending_q[i]) begin
                if (FLOOR_W'(i) > query_floor_i) above_o = 1'b1;
                if (FLOOR_W'(i) < query_floor_i) below_o = 1'b1;
            end
        end
    end

    assign pending_o = pending_q;
endmodule

// File: rtl/elevator_control_top.sv
// Single-car SCAN elevator controller: FSM, travel timer and door timer.
module elevator_control_top
    import elevator_pkg::*;
#(
    parameter int FLOOR_TRAVEL_CYCLES = 2,
    parameter int DOOR_OPEN_CYCLES    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOOR_W-1:0] requested_floor,
    input  logic               sensor,
    input  logic               open_close_door,
    output logic [FLOOR_W-1:0] current_floor,
    output logic               elevator_direction,
    output logic               door_open
);
    localparam int TW = $clog2(FLOOR_TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_OPEN_CYCLES + 1);

    state_e             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_q, dir_d;
    logic               door_q, door_d;
    logic [TW-1:0]      travel_q, travel_d;
    logic [DW-1:0]      dtmr_q, dtmr_d;

    logic                  clr_en;
    logic [FLOOR_W-1:0]    clr_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  above, below, ahead, behind, at_limit;
    logic [FLOOR_W-1:0]    next_floor;

    elevator_request_queue u_queue (
        .clk           (clk),
        .reset         (reset),
        .set_floor_i   (requested_floor),
        .clr_en_i      (clr_en),
        .clr_floor_i   (clr_floor),
        .query_floor_i (floor_q),
        .pending_o     (pending),
        .above_o       (above),
        .below_o       (below)
    );

    assign ahead      = (dir_q == DIR_UP) ? above : below;
    assign behind     = (dir_q == DIR_UP) ? below : above;
    assign next_floor = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    assign at_limit   = (dir_q == DIR_UP) ? (floor_q == MAX_FLOOR) : (floor_q == MIN_FLOOR);

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        door_d    = door_q;
        travel_d  = travel_q;
        dtmr_d    = dtmr_q;
        clr_en    = 1'b0;
        clr_floor = floor_q;
        case (state_q)
            IDLE: begin
                if (pending[floor_q] || requested_floor == floor_q || open_close_door) begin
                    clr_en  = 1'b1;
                    state_d = DOOR_OPEN;
                    door_d  = 1'b1;
                    dtmr_d  = DW'(DOOR_OPEN_CYCLES);
                end else if (ahead || behind) begin
                    state_d  = MOVING;
                    travel_d = '0;
                    if (!ahead) dir_d = ~dir_q;
                end
            end
            MOVING: begin
                if (travel_q == TW'(FLOOR_TRAVEL_CYCLES - 1)) begin
                    travel_d = '0;
                    // Nothing left ahead means we would overshoot; park instead.
                    if (at_limit || !ahead) begin
                        state_d = IDLE;
                    end else begin
                        floor_d = next_floor;
                        if (pending[next_floor] || requested_floor == next_floor) begin
                            clr_en    = 1'b1;
                            clr_floor = next_floor;
                            state_d   = DOOR_OPEN;
                            door_d    = 1'b1;
                            dtmr_d    = DW'(DOOR_OPEN_CYCLES);
                        end
                    end
                end else begin
                    travel_d = travel_q + TW'(1);
                end
            end
            DOOR_OPEN: begin
                clr_en = 1'b1;
                if (sensor) begin
                    dtmr_d = DW'(DOOR_OPEN_CYCLES);
                end else if (open_close_door || dtmr_q == DW'(1)) begin
                    door_d   = 1'b0;
                    dtmr_d   = '0;
                    travel_d = '0;
                    if (ahead) begin
                        state_d = MOVING;
                    end else if (behind) begin
                        state_d = MOVING;
                        dir_d   = ~dir_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    dtmr_d = dtmr_q - DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            floor_q  <= MIN_FLOOR;
            dir_q    <= DIR_UP;
            door_q   <= 1'b0;
            travel_q <= '0;
            dtmr_q   <= '0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_q    <= dir_d;
            door_q   <= door_d;
            travel_q <= travel_d;
            dtmr_q   <= dtmr_d;
        end
    end

    assign current_floor      = floor_q;
    assign elevator_direction = dir_q;
    assign door_open          = door_q;
endmodule

// File: tb/tb_elevator_control_top.sv
// Scoreboard bench: expected output-change events (with cycle gaps) checked by a monitor.
module tb_elevator_control_top;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] requested_floor = 4'd0;
    logic       sensor = 1'b0;
    logic       open_close_door = 1'b0;
    logic [3:0] current_floor;
    logic       elevator_direction;
    logic       door_open;

    elevator_control_top #(.FLOOR_TRAVEL_CYCLES(2), .DOOR_OPEN_CYCLES(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .requested_floor    (requested_floor),
        .sensor             (sensor),
        .open_close_door    (open_close_door),
        .current_floor      (current_floor),
        .elevator_direction (elevator_direction),
        .door_open          (door_open)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] floor;
        logic       dir;
        logic       door;
        int         gap;   // cycles since previous output change; -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    function automatic void push(input logic [3:0] f, input logic d, input logic o, input int g);
        exp_t e;
        e.floor = f; e.dir = d; e.door = o; e.gap = g;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    task automatic wait_edge(input int e);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < e);
    endtask

    // Monitor: an output change is the DUT "presenting" a new response.
    initial begin
        logic [5:0] prev = '0;
        logic [5:0] cur;
        bit         have = 1'b0;
        int         last = 0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {current_floor, elevator_direction, door_open};
                if (!have || cur !== prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event at cycle %0d: floor=%0d dir=%0d door=%0d",
                                 cyc, current_floor, elevator_direction, door_open);
                    end else begin
                        e = exp_q.pop_front();
                        chk("floor", int'(current_floor), int'(e.floor));
                        chk("direction", int'(elevator_direction), int'(e.dir));
                        chk("door_open", int'(door_open), int'(e.door));
                        if (e.gap >= 0) chk("event_gap", cyc - last, e.gap);
                    end
                    prev = cur;
                    last = cyc;
                    have = 1'b1;
                end
            end
        end
    end

    initial begin
        // Reset state
        push(4'd1, 1'b1, 1'b0, -1);
        wait_edge(1);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Floor 1 -> 3 with a 3-cycle door hold, then idle
        push(4'd2, 1'b1, 1'b0, 5);
        push(4'd3, 1'b1, 1'b1, 2);
        push(4'd3, 1'b1, 1'b0, 3);
        wait_edge(2);  requested_floor = 4'd3;
        wait_edge(3);  requested_floor = 4'd0;

        // Floor 3 -> 1 going down, passing 2 without stopping
        push(4'd3, 1'b0, 1'b0, 3);
        push(4'd2, 1'b0, 1'b0, 2);
        push(4'd1, 1'b0, 1'b1, 2);
        push(4'd1, 1'b0, 1'b0, 3);
        wait_edge(12); requested_floor = 4'd1;
        wait_edge(13); requested_floor = 4'd0;

        // Requests 2 then 4; stop at both; re-request 4 on arrival is absorbed
        push(4'd1, 1'b1, 1'b0, 3);
        push(4'd2, 1'b1, 1'b1, 2);
        push(4'd2, 1'b1, 1'b0, 3);
        push(4'd3, 1'b1, 1'b0, 2);
        push(4'd4, 1'b1, 1'b1, 2);
        push(4'd4, 1'b1, 1'b0, 3);
        wait_edge(22); requested_floor = 4'd2;
        wait_edge(23); requested_floor = 4'd4;
        wait_edge(24); requested_floor = 4'd0;
        wait_edge(32); requested_floor = 4'd4;
        wait_edge(33); requested_floor = 4'd0;

        // Manual open at idle, then open and close early with a second press
        push(4'd4, 1'b1, 1'b1, 2);
        push(4'd4, 1'b1, 1'b0, 3);
        wait_edge(37); open_close_door = 1'b1;
        wait_edge(38); open_close_door = 1'b0;
        push(4'd4, 1'b1, 1'b1, 2);
        push(4'd4, 1'b1, 1'b0, 2);
        wait_edge(42); open_close_door = 1'b1;
        wait_edge(43); open_close_door = 1'b0;
        wait_edge(44); open_close_door = 1'b1;
        wait_edge(45); open_close_door = 1'b0;

        // Obstruction for 10 cycles, button ignored meanwhile, close 3 cycles later
        push(4'd4, 1'b1, 1'b1, 3);
        push(4'd4, 1'b1, 1'b0, 13);
        wait_edge(47); open_close_door = 1'b1;
        wait_edge(48); open_close_door = 1'b0; sensor = 1'b1;
        wait_edge(52); open_close_door = 1'b1;
        wait_edge(53); open_close_door = 1'b0;
        wait_edge(58); sensor = 1'b0;

        wait_edge(75);
        chk("events_outstanding", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
